pic_fetch_unit: RTL
===================

// Module: pic_fetch_unit
// PURPOSE
//   Instruction fetch stage of the 14-bit PIC-style core; drives the program ROM address and consumes its word.
//   Holds PC, instruction register (IR) and the hardware return stack.
//   Resolves GOTO/CALL/RETURN/RETLW/RETFIE locally; takes skip and PC-write requests from execute.
//   Two-stage overlap: fetch PC while execute consumes IR.
// PARAMETERS
//   ADDR_W        11   program address width (2K words)
//   DATA_W        14   instruction width
//   STACK_DEPTH   8    return stack entries (power of 2)
//   RESET_VECTOR  0    PC value after reset
// PORTS
//   clk            in   1        system clock, rising edge
//   reset          in   1        synchronous, active-high
//   rom_addr_out   out  ADDR_W   = PC; ROM is combinational, word returns same cycle
//   rom_data_in    in   DATA_W   ROM word at rom_addr_out
//   stall          in   1        execute busy; freeze all state
//   skip           in   1        execute: discard the word being fetched (BTFSC/DECFSZ true)
//   pc_load        in   1        execute wrote PCL; redirect fetch
//   pc_load_value  in   ADDR_W   redirect target
//   ir_out         out  DATA_W   instruction for execute
//   ir_valid       out  1        ir_out is a real instruction (0 = flushed bubble, treat as NOP)
//   ir_pc          out  ADDR_W   address ir_out was fetched from
// BEHAVIOUR
// - Clock and reset: single clock (clk); reset synchronous, active-high. During reset: PC=RESET_VECTOR, IR=14'h0000,
//   ir_valid=0, ir_pc=0, stack pointer=0, all stack entries=0. First valid IR is the word at RESET_VECTOR one cycle after reset drops.
// - Decode of IR (only when ir_valid=1): CALL=2'b10,0,k[10:0]; GOTO=2'b10,1,k[10:0]; RETURN=14'h0008;
//   RETFIE=14'h0009; RETLW=4'b1101,xx,k[7:0]. All else = sequential.
// - Next-PC priority per cycle (stall=0): pc_load > CALL/GOTO > RETURN/RETFIE/RETLW > skip > PC+1.
//   GOTO: PC<=k. CALL: push PC (=ir_pc+1, the return address), PC<=k. RET*: PC<=pop.
//   pc_load: PC<=pc_load_value. Any redirect or skip: IR<=14'h0000, ir_valid<=0 (flush).
//   Otherwise IR<=rom_data_in, ir_pc<=PC, ir_valid<=1.
// - Redirect/skip cost exactly one bubble cycle; back-to-back GOTO target word is fetched on the cycle after the GOTO executes.
// - skip or pc_load asserted while ir_valid=1 and IR is itself a control-flow op: pc_load wins; skip ignored.
// - stall=1: PC, IR, ir_valid, ir_pc, stack hold; skip/pc_load ignored (execute holds them until stall drops).
// - PC arithmetic: ADDR_W bits, PC+1 from 11'h7FF wraps to 11'h000; CALL/GOTO use k[ADDR_W-1:0] only.
// - Stack: circular, log2(STACK_DEPTH)-bit pointer. Push writes [sp], sp++; pop sp--, reads [sp].
//   9th push overwrites oldest entry silently; pop on empty wraps and returns stale entry; no flags.
// - Bubble (ir_valid=0) never triggers decode, even if IR bits match an opcode.
// - reset mid-instruction (e.g. during stall or pending skip): reset wins, everything reinitialised.
// - rom_addr_out is purely PC (registered); no combinational path from ROM data to address.
// TESTING
// 1 Reset: hold reset 3 cycles with ROM 0:303B,1:00A4 -> rom_addr_out=0, ir_valid=0; cycle after release IR=303B, ir_pc=0, PC=1.
// 2 CALL/RETURN: 7:2012 at addr 8? place CALL 0x12 at 0x08, 0x1C=0008 -> PC 0x12 after CALL, one bubble, RETURN
//   pops 0x009; ir_pc sequence 08,-,12..1C,-,09.
// 3 GOTO loop: 0x17=2816 -> PC sequence 17,18,16,17 with ir_valid 1,0,1 after each GOTO.
// 4 skip: assert skip 1 cycle while IR at 0x16 -> word at 0x17 flushed (ir_valid=0), next IR from 0x18.
// 5 Stack overflow: 9 nested CALLs from 0x100..0x108, then 9 RETURNs -> first 8 return 0x109..0x102 descending, 9th returns 0x109.
// 6 stall + pc_load: stall 4 cycles at PC=0x005 -> all outputs frozen; then pc_load=1 value 0x7FF -> bubble, IR=ROM[7FF], next PC 0x000.

Source files
------------

// File: rtl/pic_fetch_unit.sv
// -----------------------------------------------------------------------------
// pic_fetch_unit
//   Instruction fetch stage of the 14-bit PIC-style core. Owns the PC, the
//   instruction register and the hardware return stack. GOTO/CALL/RETURN/
//   RETFIE/RETLW are resolved here from the IR; execute only supplies skip
//   and PC-write requests. The PC fetches the next word while execute
//   consumes the IR, so every redirect or skip costs exactly one bubble.
//
// Ports
//   clk            in   1       system clock, rising edge
//   reset          in   1       synchronous, active-high
//   rom_addr_out   out  ADDR_W  program ROM address (the PC register)
//   rom_data_in    in   DATA_W  ROM word at rom_addr_out, same cycle
//   stall          in   1       execute busy: freeze all state
//   skip           in   1       discard the word currently being fetched
//   pc_load        in   1       execute wrote PCL: redirect fetch
//   pc_load_value  in   ADDR_W  redirect target
//   ir_out         out  DATA_W  instruction for execute
//   ir_valid       out  1       0 = flushed bubble, treat as NOP
//   ir_pc          out  ADDR_W  address ir_out was fetched from
// -----------------------------------------------------------------------------
module pic_fetch_unit #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 14,
    parameter int STACK_DEPTH  = 8,   // power of 2, at least 2
    parameter int RESET_VECTOR = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_addr_out,
    input  logic [DATA_W-1:0] rom_data_in,
    input  logic              stall,
    input  logic              skip,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_value,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] ir_pc
);

    localparam int SP_W = $clog2(STACK_DEPTH);

    // Program addresses wrap modulo the ROM size.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] a);
        return a + 1'b1;
    endfunction

    logic [ADDR_W-1:0] pc_p0;
    logic [DATA_W-1:0] ir_p1;
    logic              vld_p1;
    logic [ADDR_W-1:0] ir_pc_p1;
    logic [SP_W-1:0]   sp;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];

    logic              is_call;
    logic              is_goto;
    logic              is_ret;
    logic [SP_W-1:0]   sp_dec;
    logic [ADDR_W-1:0] next_pc;
    logic              flush;
    logic              do_push;
    logic              do_pop;

    // A bubble carries IR=0 but must never be decoded, hence the vld_p1 gate.
    assign is_call = vld_p1 && (ir_p1[DATA_W-1 -: 3] == 3'b100);
    assign is_goto = vld_p1 && (ir_p1[DATA_W-1 -: 3] == 3'b101);
    assign is_ret  = vld_p1 && ((ir_p1 == DATA_W'(14'h0008)) ||
                                (ir_p1 == DATA_W'(14'h0009)) ||
                                (ir_p1[DATA_W-1 -: 4] == 4'b1101));

    assign sp_dec = sp - 1'b1;

    // pc_load beats the IR's own control flow; control flow beats skip.
    always_comb begin
        next_pc = pc_inc(pc_p0);
        flush   = 1'b0;
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (pc_load) begin
            next_pc = pc_load_value;
            flush   = 1'b1;
        end else if (is_call) begin
            next_pc = ir_p1[ADDR_W-1:0];
            flush   = 1'b1;
            do_push = 1'b1;
        end else if (is_goto) begin
            next_pc = ir_p1[ADDR_W-1:0];
            flush   = 1'b1;
        end else if (is_ret) begin
            next_pc = stack[sp_dec];
            flush   = 1'b1;
            do_pop  = 1'b1;
        end else if (skip) begin
            flush   = 1'b1;
        end
    end

    // Stage p0 (PC / ROM fetch) -> stage p1 (IR handed to execute)
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0    <= ADDR_W'(RESET_VECTOR);
            ir_p1    <= '0;
            vld_p1   <= 1'b0;
            ir_pc_p1 <= '0;
            sp       <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else if (!stall) begin
            pc_p0    <= next_pc;
            ir_p1    <= flush ? '0 : rom_data_in;
            vld_p1   <= !flush;
            ir_pc_p1 <= pc_p0;
            // Circular stack: overflow overwrites the oldest entry and
            // underflow returns whatever stale entry the pointer lands on.
            if (do_push) begin
                stack[sp] <= pc_inc(ir_pc_p1);
                sp        <= sp + 1'b1;
            end else if (do_pop) begin
                sp <= sp_dec;
            end
        end
    end

    assign rom_addr_out = pc_p0;
    assign ir_out       = ir_p1;
    assign ir_valid     = vld_p1;
    assign ir_pc        = ir_pc_p1;

endmodule
